uart_rx_ack_fifo: RTL and testbench

//   Byte FIFO between the UART RX deserializer and the BLE connection monitor.

---
 rtl/uart_rx_ack_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_rx_ack_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ack_fifo.sv
// Byte FIFO between the UART RX deserializer and the BLE connection monitor.
// Drops framing-error and overflow bytes and serves the rest through a valid/get/ready pull handshake.
module uart_rx_ack_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_frame_err,
    input  logic                       flush,
    output logic                       ack_valid,
    input  logic                       get_ack_byte,
    output logic                       ack_ready,
    output logic [7:0]                 ack_byte,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       clr_overflow,
    output logic [CNT_W-1:0]           ovf_drops,
    output logic [CNT_W-1:0]           ferr_drops
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL    = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        RD_IDLE,
        RD_ACK
    } rdState_e;

    rdState_e         state_q, state_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [7:0]       ackByte_q, ackByte_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] ovfCnt_q, ovfCnt_d;
    logic [CNT_W-1:0] ferrCnt_q, ferrCnt_d;
    logic [7:0]       mem [DEPTH];

    logic pop;
    logic goodWr;
    logic wrEn;
    logic ovfEv;
    logic ferrEv;

    // A pop frees a slot on the same edge, so a full FIFO still accepts a write when it is popped.
    always_comb begin
        state_d   = state_q;
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        level_d   = level_q;
        ackByte_d = ackByte_q;
        ovf_d     = ovf_q;
        ovfCnt_d  = ovfCnt_q;
        ferrCnt_d = ferrCnt_q;

        pop    = (state_q == RD_IDLE) && get_ack_byte && (level_q != '0);
        goodWr = rx_valid && !rx_frame_err;
        wrEn   = goodWr && !flush && ((level_q != FULL) || pop);
        ovfEv  = goodWr && !flush && (level_q == FULL) && !pop;
        ferrEv = rx_valid && rx_frame_err;

        case (state_q)
            RD_IDLE: begin
                if (pop) begin
                    ackByte_d = mem[rdPtr_q];
                    state_d   = RD_ACK;
                end
            end
            RD_ACK:  state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase

        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
        end else begin
            if (wrEn) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            if (wrEn && !pop) begin
                level_d = level_q + LVL_W'(1);
            end else if (pop && !wrEn) begin
                level_d = level_q - LVL_W'(1);
            end
        end

        // The debug clear wins over any drop event in the same cycle.
        if (clr_overflow) begin
            ovf_d     = 1'b0;
            ovfCnt_d  = '0;
            ferrCnt_d = '0;
        end else begin
            if (ovfEv) begin
                ovf_d = 1'b1;
                if (ovfCnt_q != CNT_MAX) begin
                    ovfCnt_d = ovfCnt_q + CNT_W'(1);
                end
            end
            if (ferrEv && (ferrCnt_q != CNT_MAX)) begin
                ferrCnt_d = ferrCnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RD_IDLE;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            level_q   <= '0;
            ackByte_q <= 8'h00;
            ovf_q     <= 1'b0;
            ovfCnt_q  <= '0;
            ferrCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            level_q   <= level_d;
            ackByte_q <= ackByte_d;
            ovf_q     <= ovf_d;
            ovfCnt_q  <= ovfCnt_d;
            ferrCnt_q <= ferrCnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr_q] <= rx_data;
        end
    end

    assign ack_valid  = (state_q == RD_IDLE) && (level_q != '0);
    assign ack_ready  = (state_q == RD_ACK);
    assign ack_byte   = ackByte_q;
    assign level      = level_q;
    assign overflow   = ovf_q;
    assign ovf_drops  = ovfCnt_q;
    assign ferr_drops = ferrCnt_q;

endmodule

// File: tb/tb_uart_rx_ack_fifo.sv
// Scoreboard bench for uart_rx_ack_fifo: directed writes push expected bytes,
// a monitor pops and compares on every ack_ready pulse.
module tb_uart_rx_ack_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       flush;
    logic       ack_valid;
    logic       get_ack_byte;
    logic       ack_ready;
    logic [7:0] ack_byte;
    logic [4:0] level;
    logic       overflow;
    logic       clr_overflow;
    logic [7:0] ovf_drops;
    logic [7:0] ferr_drops;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] expQ [$];
    logic [7:0] msg [9];

    uart_rx_ack_fifo #(.DEPTH(16), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .flush        (flush),
        .ack_valid    (ack_valid),
        .get_ack_byte (get_ack_byte),
        .ack_ready    (ack_ready),
        .ack_byte     (ack_byte),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .ovf_drops    (ovf_drops),
        .ferr_drops   (ferr_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic ferr, input logic store);
        rx_data      = d;
        rx_frame_err = ferr;
        rx_valid     = 1'b1;
        if (store) expQ.push_back(d);
        tick();
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
    endtask

    task automatic doGet();
        get_ack_byte = 1'b1;
        tick();
        checkOutput("ackLatency", {31'd0, ack_ready}, 32'd1);
        get_ack_byte = 1'b0;
        tick();
    endtask

    // Monitor: every ack_ready pulse must deliver the oldest outstanding expected byte.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (ack_ready === 1'b1) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL ackByte unexpected pulse actual=%0h required=none", ack_byte);
                end else begin
                    exp = expQ.pop_front();
                    if (ack_byte !== exp) begin
                        errors++;
                        $display("[TB] FAIL ackByte actual=%0h required=%0h", ack_byte, exp);
                    end
                end
            end
        end
    end

    initial begin
        msg[0] = 8'h4F; msg[1] = 8'h4B; msg[2] = 8'h2B;
        msg[3] = 8'h43; msg[4] = 8'h4F; msg[5] = 8'h4E;
        msg[6] = 8'h4E; msg[7] = 8'h0D; msg[8] = 8'h0A;

        rst          = 1'b1;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
        flush        = 1'b0;
        get_ack_byte = 1'b0;
        clr_overflow = 1'b0;
        tick();
        checkOutput("rstLevel",    {27'd0, level},     32'd0);
        checkOutput("rstAckValid", {31'd0, ack_valid}, 32'd0);
        checkOutput("rstAckReady", {31'd0, ack_ready}, 32'd0);
        checkOutput("rstAckByte",  {24'd0, ack_byte},  32'd0);
        checkOutput("rstOverflow", {31'd0, overflow},  32'd0);
        checkOutput("rstOvfDrops", {24'd0, ovf_drops}, 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] message write and pull");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(msg[i], 1'b0, 1'b1);
            tick();
            tick();
        end
        checkOutput("msgLevel", {27'd0, level}, 32'd9);
        checkOutput("msgAckValid", {31'd0, ack_valid}, 32'd1);
        for (int i = 0; i < 9; i++) doGet();
        checkOutput("msgLevelEnd", {27'd0, level}, 32'd0);
        checkOutput("msgAckValidEnd", {31'd0, ack_valid}, 32'd0);

        $display("[TB] overflow");
        for (int i = 0; i < 18; i++) applyStimulus(8'(i), 1'b0, i < 16);
        checkOutput("fullLevel", {27'd0, level}, 32'd16);
        checkOutput("fullOverflow", {31'd0, overflow}, 32'd1);
        checkOutput("fullOvfDrops", {24'd0, ovf_drops}, 32'd2);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checkOutput("clrOverflow", {31'd0, overflow}, 32'd0);
        checkOutput("clrOvfDrops", {24'd0, ovf_drops}, 32'd0);

        $display("[TB] write into full on pop edge");
        get_ack_byte = 1'b1;
        rx_data      = 8'hAA;
        rx_valid     = 1'b1;
        expQ.push_back(8'hAA);
        tick();
        get_ack_byte = 1'b0;
        rx_valid     = 1'b0;
        checkOutput("popWrLevel", {27'd0, level}, 32'd16);
        checkOutput("popWrOverflow", {31'd0, overflow}, 32'd0);
        checkOutput("popWrAckReady", {31'd0, ack_ready}, 32'd1);
        tick();
        for (int i = 0; i < 16; i++) doGet();
        checkOutput("drainLevel", {27'd0, level}, 32'd0);

        $display("[TB] framing error");
        applyStimulus(8'h55, 1'b1, 1'b0);
        applyStimulus(8'h3A, 1'b0, 1'b1);
        checkOutput("ferrDrops", {24'd0, ferr_drops}, 32'd1);
        checkOutput("ferrLevel", {27'd0, level}, 32'd1);
        doGet();

        $display("[TB] reset during read");
        for (int i = 0; i < 4; i++) applyStimulus(8'h10 + 8'(i), 1'b0, 1'b0);
        get_ack_byte = 1'b1;
        tick();
        get_ack_byte = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rstRdAckReady", {31'd0, ack_ready}, 32'd0);
        checkOutput("rstRdLevel", {27'd0, level}, 32'd0);
        checkOutput("rstRdAckByte", {24'd0, ack_byte}, 32'd0);
        checkOutput("rstRdFerr", {24'd0, ferr_drops}, 32'd0);
        rst = 1'b0;
        tick();
        applyStimulus(8'h41, 1'b0, 1'b1);
        doGet();
        checkOutput("rstRdByte", {24'd0, ack_byte}, 32'h41);

        $display("[TB] streaming wrap");
        for (int i = 0; i < 40; i++) begin
            rx_data      = 8'h80 + 8'(i * 3);
            rx_valid     = 1'b1;
            get_ack_byte = 1'b1;
            expQ.push_back(8'h80 + 8'(i * 3));
            tick();
            rx_valid     = 1'b0;
            get_ack_byte = 1'b0;
            checkOutput("streamLevelMax", {31'd0, level <= 5'd3}, 32'd1);
            tick();
        end
        doGet();
        checkOutput("streamLevelEnd", {27'd0, level}, 32'd0);
        checkOutput("streamOverflow", {31'd0, overflow}, 32'd0);

        $display("[TB] flush");
        for (int i = 0; i < 3; i++) applyStimulus(8'hC0 + 8'(i), 1'b0, 1'b0);
        flush    = 1'b1;
        rx_data  = 8'h99;
        rx_valid = 1'b1;
        tick();
        flush    = 1'b0;
        rx_valid = 1'b0;
        checkOutput("flushLevel", {27'd0, level}, 32'd0);
        checkOutput("flushAckValid", {31'd0, ack_valid}, 32'd0);
        checkOutput("flushOvfDrops", {24'd0, ovf_drops}, 32'd0);
        get_ack_byte = 1'b1;
        tick();
        get_ack_byte = 1'b0;
        checkOutput("getEmpty", {31'd0, ack_ready}, 32'd0);

        $display("[TB] counter saturation and clear priority");
        for (int i = 0; i < 276; i++) applyStimulus(8'(i), 1'b0, 1'b0);
        checkOutput("satLevel", {27'd0, level}, 32'd16);
        checkOutput("satOvfDrops", {24'd0, ovf_drops}, 32'd255);
        checkOutput("satOverflow", {31'd0, overflow}, 32'd1);
        clr_overflow = 1'b1;
        rx_valid     = 1'b1;
        rx_data      = 8'h77;
        tick();
        clr_overflow = 1'b0;
        rx_valid     = 1'b0;
        checkOutput("clrWinsOverflow", {31'd0, overflow}, 32'd0);
        checkOutput("clrWinsOvfDrops", {24'd0, ovf_drops}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("finalLevel", {27'd0, level}, 32'd0);

        tick();
        tick();
        checkOutput("queueEmpty", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
